fifo_rd_stream: RTL and testbench

Read-side drain stage for the asynchronous FIFO. It lives in the `rdclk` domain and issues `pop` against the FIFO's `empty`/`rddata` read port. It absorbs the FIFO's one-cycle registered read latency and presents the words as a valid/ready stream to the downstream consumer. It sustains one word per cycle, and no consumer-side signal appears combinationally on `pop`.

---
 rtl/fifo_rd_stream_pkg.sv | 14 +
 rtl/fifo_rd_stream_if.sv | 29 ++
 rtl/fifo_rd_skid_buf.sv | 52 +++++
 rtl/fifo_rd_stream.sv | 62 ++++++
 tb/tb_fifo_rd_stream.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// Shared sizing and helper types for the FIFO read-side drain stage.
package fifo_rd_stream_pkg;

    localparam int BUF_DEPTH = 3;

    typedef logic [1:0] ptr_t;
    typedef logic [1:0] occ_t;

    // Circular pointer advance for a non-power-of-two depth.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(BUF_DEPTH - 1)) ? ptr_t'(0) : ptr_t'(p + ptr_t'(1));
    endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus downstream valid/ready stream, bundled for the drain stage.
interface fifo_rd_stream_if #(
    parameter int DWIDTH = 8
);
    logic              empty;
    logic [DWIDTH-1:0] rddata;
    logic              pop;
    logic              m_valid;
    logic              m_ready;
    logic [DWIDTH-1:0] m_data;

    modport master (
        input  empty,
        input  rddata,
        input  m_ready,
        output pop,
        output m_valid,
        output m_data
    );

    modport slave (
        output empty,
        output rddata,
        output m_ready,
        input  pop,
        input  m_valid,
        input  m_data
    );
endinterface

// File: rtl/fifo_rd_skid_buf.sv
// Three-entry circular buffer: land writes at tail, fire reads from head.
module fifo_rd_skid_buf
    import fifo_rd_stream_pkg::*;
#(
    parameter int DWIDTH = 8
) (
    input  logic              rdclk,
    input  logic              reset_L,
    input  logic              i_wr_en,
    input  logic [DWIDTH-1:0] i_wr_data,
    input  logic              i_rd_en,
    output logic [DWIDTH-1:0] o_rd_data,
    output occ_t              o_count
);

    ptr_t r_head;
    ptr_t r_tail;
    occ_t r_count;
    logic [BUF_DEPTH-1:0][DWIDTH-1:0] w_entries;

    generate
        for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
            logic [DWIDTH-1:0] r_data;
            always_ff @(posedge rdclk) begin
                if (i_wr_en && (r_tail == ptr_t'(gi))) begin
                    r_data <= i_wr_data;
                end
            end
            assign w_entries[gi] = r_data;
        end
    endgenerate

    always_ff @(posedge rdclk) begin
        if (!reset_L) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_wr_en) begin
                r_tail <= ptr_inc(r_tail);
            end
            if (i_rd_en) begin
                r_head <= ptr_inc(r_head);
            end
            r_count <= r_count + occ_t'(i_wr_en) - occ_t'(i_rd_en);
        end
    end

    assign o_rd_data = w_entries[r_head];
    assign o_count   = r_count;

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains the FIFO read port into a valid/ready stream, hiding the one-cycle read latency.
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int CWIDTH = 16
) (
    input  logic               rdclk,
    input  logic               reset_L,
    input  logic               en,
    fifo_rd_stream_if.master   bus,
    output logic [CWIDTH-1:0]  word_cnt,
    output logic               idle
);

    logic              r_inflight;
    logic [CWIDTH-1:0] r_word_cnt;
    occ_t              w_count;
    logic [2:0]        w_pending;
    logic              w_pop;
    logic              w_valid;
    logic              w_fire;
    logic [DWIDTH-1:0] w_head_data;

    // Reserve a slot for every in-flight word so a land can never overflow;
    // m_ready is deliberately kept out of this path.
    assign w_pending = {1'b0, w_count} + {2'b00, r_inflight};
    assign w_pop     = reset_L & en & ~bus.empty & (w_pending < 3'(BUF_DEPTH));
    assign w_valid   = (w_count != '0);
    assign w_fire    = w_valid & bus.m_ready;

    always_ff @(posedge rdclk) begin
        if (!reset_L) begin
            r_inflight <= 1'b0;
            r_word_cnt <= '0;
        end else begin
            r_inflight <= w_pop;
            if (w_fire) begin
                r_word_cnt <= r_word_cnt + CWIDTH'(1);
            end
        end
    end

    fifo_rd_skid_buf #(
        .DWIDTH (DWIDTH)
    ) u_skid (
        .rdclk     (rdclk),
        .reset_L   (reset_L),
        .i_wr_en   (r_inflight),
        .i_wr_data (bus.rddata),
        .i_rd_en   (w_fire),
        .o_rd_data (w_head_data),
        .o_count   (w_count)
    );

    assign bus.pop     = w_pop;
    assign bus.m_valid = w_valid;
    assign bus.m_data  = w_head_data;
    assign word_cnt    = r_word_cnt;
    assign idle        = (w_count == '0) & ~r_inflight;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a FIFO stand-in and a word-accounting reference model.
module tb_fifo_rd_stream;

    localparam int DW = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset_L;
    logic          en;
    logic [CW-1:0] word_cnt;
    logic          idle;

    always #5 clk = ~clk;

    fifo_rd_stream_if #(.DWIDTH(DW)) bus ();

    fifo_rd_stream #(
        .DWIDTH (DW),
        .CWIDTH (CW)
    ) dut (
        .rdclk    (clk),
        .reset_L  (reset_L),
        .en       (en),
        .bus      (bus),
        .word_cnt (word_cnt),
        .idle     (idle)
    );

    // FIFO stand-in: registered read data, flushed by the shared reset.
    logic [DW-1:0] mem [0:255];
    int            wr_ptr = 0;
    int            rd_ptr = 0;

    assign bus.empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (!reset_L) begin
            rd_ptr <= wr_ptr;
        end else if (bus.pop) begin
            bus.rddata <= mem[rd_ptr];
            rd_ptr     <= rd_ptr + 1;
        end
    end

    // Reference model: words fetched but not delivered, words landed, delivered total.
    int            m_out   = 0;
    int            m_land  = 0;
    int            m_deliv = 0;
    int            m_rd    = 0;
    bit            m_pend  = 1'b0;
    logic [DW-1:0] exp_q [$];
    logic          exp_pop;
    bit            armed   = 1'b0;

    int errors = 0;
    int checks = 0;
    int n_pop  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [DW-1:0] v);
        mem[wr_ptr] = v;
        wr_ptr++;
    endtask

    // One clock cycle: compare outputs against the model, advance the model, wait for next cycle.
    task automatic step();
        bit fire;
        #1;
        exp_pop = reset_L && en && (m_rd != wr_ptr) && (m_out < 3);
        if (armed) begin
            chk("pop", 32'(bus.pop), 32'(exp_pop));
            chk("m_valid", 32'(bus.m_valid), 32'(m_land > 0));
            chk("idle", 32'(idle), 32'(m_out == 0));
            chk("word_cnt", 32'(word_cnt), 32'(m_deliv % 65536));
            if (m_land > 0) begin
                chk("m_data", 32'(bus.m_data), 32'(exp_q[0]));
            end
        end
        if (bus.pop) n_pop++;
        if (!reset_L) begin
            m_out   = 0;
            m_land  = 0;
            m_deliv = 0;
            m_pend  = 1'b0;
            m_rd    = wr_ptr;
            exp_q.delete();
            armed   = 1'b1;
        end else begin
            fire = (m_land > 0) && bus.m_ready;
            if (fire) begin
                void'(exp_q.pop_front());
                m_land--;
                m_out--;
                m_deliv++;
            end
            if (m_pend) m_land++;
            m_pend = exp_pop;
            if (exp_pop) begin
                exp_q.push_back(mem[m_rd]);
                m_rd++;
                m_out++;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int p0;
        int c;

        reset_L     = 1'b0;
        en          = 1'b0;
        bus.m_ready = 1'b0;
        repeat (2) step();

        // Idle with an empty FIFO
        reset_L = 1'b1;
        en      = 1'b1;
        repeat (10) step();
        chk("t1_idle", 32'(idle), 32'd1);
        chk("t1_word_cnt", 32'(word_cnt), 32'd0);
        chk("t1_m_valid", 32'(bus.m_valid), 32'd0);
        $display("t1 empty idle: word_cnt=%0d idle=%0d", word_cnt, idle);

        // Full-rate streaming of 8 words
        bus.m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push(8'(i));
        p0 = n_pop;
        c  = 0;
        while (!bus.m_valid && c < 20) begin
            step();
            c++;
        end
        chk("t2_latency", 32'(c), 32'd2);
        chk("t2_first", 32'(bus.m_data), 32'h01);
        repeat (6) step();
        chk("t2_pops8", 32'(n_pop - p0), 32'd8);
        repeat (6) step();
        chk("t2_pops_stop", 32'(n_pop - p0), 32'd8);
        chk("t2_word_cnt", 32'(word_cnt), 32'd8);
        chk("t2_idle", 32'(idle), 32'd1);
        $display("t2 stream: latency=%0d word_cnt=%0d", c, word_cnt);

        // Backpressure: only three words may be fetched
        bus.m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(8'(i));
        p0 = n_pop;
        repeat (10) step();
        chk("t3_pops3", 32'(n_pop - p0), 32'd3);
        chk("t3_m_valid", 32'(bus.m_valid), 32'd1);
        chk("t3_head", 32'(bus.m_data), 32'h01);
        chk("t3_idle", 32'(idle), 32'd0);
        bus.m_ready = 1'b1;
        repeat (15) step();
        chk("t3_pops8", 32'(n_pop - p0), 32'd8);
        chk("t3_word_cnt", 32'(word_cnt), 32'd16);
        $display("t3 backpressure: pops=%0d word_cnt=%0d", n_pop - p0, word_cnt);

        // Toggling m_ready over 20 words
        for (int i = 0; i < 20; i++) push(8'(8'h20 + i));
        for (int i = 0; i < 60; i++) begin
            bus.m_ready = i[0];
            step();
        end
        bus.m_ready = 1'b1;
        repeat (4) step();
        chk("t4_word_cnt", 32'(word_cnt), 32'd36);
        chk("t4_idle", 32'(idle), 32'd1);
        $display("t4 toggle ready: word_cnt=%0d", word_cnt);

        // en dropped right after a pop: the in-flight word still drains
        for (int i = 0; i < 4; i++) push(8'(8'h50 + i));
        step();
        en = 1'b0;
        p0 = n_pop;
        repeat (6) step();
        chk("t5_no_pops", 32'(n_pop - p0), 32'd0);
        chk("t5_word_cnt", 32'(word_cnt), 32'd37);
        en = 1'b1;
        repeat (10) step();
        chk("t5_resume", 32'(word_cnt), 32'd40);
        $display("t5 enable gate: word_cnt=%0d", word_cnt);

        // Reset with count=2 and a word in flight
        bus.m_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(8'(8'h70 + i));
        repeat (3) step();
        chk("t6_pre_valid", 32'(bus.m_valid), 32'd1);
        reset_L = 1'b0;
        step();
        reset_L = 1'b1;
        #1;
        chk("t6_m_valid", 32'(bus.m_valid), 32'd0);
        chk("t6_pop", 32'(bus.pop), 32'd0);
        chk("t6_word_cnt", 32'(word_cnt), 32'd0);
        chk("t6_idle", 32'(idle), 32'd1);
        bus.m_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(8'(8'hA0 + i));
        repeat (10) step();
        chk("t6_refill", 32'(word_cnt), 32'd4);
        chk("t6_idle_end", 32'(idle), 32'd1);
        $display("t6 mid reset: word_cnt=%0d", word_cnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
